// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RISC-V M-extension divider sequencer
// (DIV, DIVU, REM, REMU) built on 32-bit restoring division.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; aborts any operation in flight
//   div_start  one-cycle request; honoured only in IDLE or DONE
//   div_op     00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//   dividend   rs1 operand, sampled only in the accepting cycle
//   divisor    rs2 operand, sampled only in the accepting cycle
//   div_busy   registered; high in SETUP, ITER and FIXUP
//   div_done   registered; one-cycle pulse while in DONE
//   result     registered quotient/remainder, held until the next load
//
// Timing from an accepted start in cycle T: normal divides finish with
// div_done at T+35; divide-by-zero and signed overflow finish at T+2.
module div_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_start,
    input  logic [1:0]  div_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] result
);

    typedef enum logic [2:0] {IDLE, SETUP, ITER, FIXUP, DONE} state_t;

    state_t      state, state_next;

    logic [1:0]  op_q;          // captured operation
    logic [31:0] a_q, b_q;      // captured raw operands
    logic [31:0] rem;           // partial remainder
    logic [31:0] quo;           // dividend magnitude shifting out, quotient shifting in
    logic [31:0] dvs;           // divisor magnitude
    logic [4:0]  cnt;           // ITER step counter
    logic        neg_q, neg_r;

    logic        accept;
    logic        is_signed;     // DIV / REM
    logic        is_rem;        // REM / REMU
    logic        div_zero;
    logic        sgn_ovf;
    logic [32:0] shifted;       // {rem,quo} shifted left, upper 33 bits
    logic [32:0] diff;          // trial subtraction result

    assign accept    = div_start && (state == IDLE || state == DONE);
    assign is_signed = ~op_q[0];
    assign is_rem    = op_q[1];
    assign div_zero  = (b_q == 32'd0);
    assign sgn_ovf   = is_signed && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

    // One restoring step: bring the next dividend bit into the remainder and
    // try to subtract; a clear borrow bit means the subtraction fits.
    assign shifted = {rem, quo[31]};
    assign diff    = shifted - {1'b0, dvs};

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (div_start) state_next = SETUP;
            SETUP: state_next = (div_zero || sgn_ovf) ? DONE : ITER;
            ITER:  if (cnt == 5'd31) state_next = FIXUP;
            FIXUP: state_next = DONE;
            DONE:  state_next = div_start ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_busy <= 1'b0;
            div_done <= 1'b0;
        end else begin
            div_busy <= (state_next == SETUP) || (state_next == ITER) ||
                        (state_next == FIXUP);
            div_done <= (state_next == DONE);
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= 2'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            rem    <= 32'd0;
            quo    <= 32'd0;
            dvs    <= 32'd0;
            cnt    <= 5'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= 32'd0;
        end else begin
            if (accept) begin
                op_q <= div_op;
                a_q  <= dividend;
                b_q  <= divisor;
            end
            case (state)
                SETUP: begin
                    cnt <= 5'd0;
                    rem <= 32'd0;
                    if (div_zero) begin
                        result <= is_rem ? a_q : 32'hFFFF_FFFF;
                    end else if (sgn_ovf) begin
                        result <= is_rem ? 32'd0 : 32'h8000_0000;
                    end
                    if (is_signed) begin
                        quo   <= a_q[31] ? (32'd0 - a_q) : a_q;
                        dvs   <= b_q[31] ? (32'd0 - b_q) : b_q;
                        neg_q <= a_q[31] ^ b_q[31];
                        neg_r <= a_q[31];
                    end else begin
                        quo   <= a_q;
                        dvs   <= b_q;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end
                end
                ITER: begin
                    if (!diff[32]) rem <= diff[31:0];
                    else           rem <= shifted[31:0];
                    quo <= {quo[30:0], ~diff[32]};
                    cnt <= cnt + 5'd1;
                end
                FIXUP: begin
                    if (is_rem) result <= neg_r ? (32'd0 - rem) : rem;
                    else        result <= neg_q ? (32'd0 - quo) : quo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        div_start;
    logic [1:0]  div_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        div_busy;
    logic        div_done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    div_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .div_start (div_start),
        .div_op    (div_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .div_busy  (div_busy),
        .div_done  (div_done),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a start for one cycle; returns 1 ns after the accepting edge
    // (cycle T+1). Operand buses are scrambled afterwards.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        div_start = 1'b1;
        div_op    = op;
        dividend  = a;
        divisor   = b;
        @(posedge clk); #1;
        div_start = 1'b0;
        div_op    = 2'($urandom);
        dividend  = $urandom;
        divisor   = $urandom;
    endtask

    // Called at cycle T+1; waits (bounded) for div_done and checks latency,
    // busy-cycle count and result, leaving the bench in the DONE cycle.
    task automatic finish_op(input string tag, input logic [31:0] exp_res, input int exp_lat);
        int k = 1;
        int busy_cnt = 0;
        while (!div_done && k < 60) begin
            if (div_busy) busy_cnt++;
            @(posedge clk); #1;
            k++;
        end
        check({tag, " latency"}, 32'(k), 32'(exp_lat));
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
        check({tag, " busy in done"}, {31'd0, div_busy}, 32'd0);
        check({tag, " result"}, result, exp_res);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        @(posedge clk); #1;
        start_op(op, a, b);
        finish_op(tag, exp_res, exp_lat);
        @(posedge clk); #1;
        check({tag, " done one pulse"}, {31'd0, div_done}, 32'd0);
        check({tag, " result held"}, result, exp_res);
    endtask

    initial begin
        int k;
        int pulses;
        reset     = 1'b1;
        div_start = 1'b0;
        div_op    = 2'd0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",   {31'd0, div_busy}, 32'd0);
        check("reset done",   {31'd0, div_done}, 32'd0);
        check("reset result", result, 32'd0);
        reset = 1'b0;

        // Normal path, unsigned and signed.
        run_op("divu 100/7",      OP_DIVU, 32'd100, 32'd7, 32'd14, 35);
        run_op("remu 100%7",      OP_REMU, 32'd100, 32'd7, 32'd2, 35);
        run_op("rem -7%2",        OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
        run_op("div -7/2",        OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
        run_op("div -100/7",      OP_DIV,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 35);
        run_op("rem -100%7",      OP_REM,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 35);
        run_op("div 7/-2",        OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 35);
        run_op("rem 7%-2",        OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 35);
        run_op("divu max/1",      OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 35);
        run_op("divu max/2",      OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 35);

        // Special cases resolved in SETUP.
        run_op("div 12345/0",     OP_DIV,  32'd12345, 32'd0, 32'hFFFF_FFFF, 2);
        run_op("divu 12345/0",    OP_DIVU, 32'd12345, 32'd0, 32'hFFFF_FFFF, 2);
        run_op("remu 12345%0",    OP_REMU, 32'd12345, 32'd0, 32'd12345, 2);
        run_op("rem -7%0",        OP_REM,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 2);
        run_op("div ovf",         OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_op("rem ovf",         OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);
        run_op("divu no ovf",     OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 35);

        // Reset in the middle of an operation aborts it without a done pulse.
        @(posedge clk); #1;
        start_op(OP_DIVU, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort busy",   {31'd0, div_busy}, 32'd0);
        check("abort done",   {31'd0, div_done}, 32'd0);
        check("abort result", result, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (div_done || div_busy) pulses++;
        end
        check("abort no activity", 32'(pulses), 32'd0);
        run_op("divu 9/3 after reset", OP_DIVU, 32'd9, 32'd3, 32'd3, 35);

        // Start pulse while busy is ignored; start in DONE chains immediately.
        @(posedge clk); #1;
        start_op(OP_DIVU, 32'd100, 32'd7);
        k = 1;
        while (!div_done && k < 60) begin
            if (k == 5) begin
                div_start = 1'b1;
                div_op    = OP_DIV;
                dividend  = 32'd50;
                divisor   = 32'd5;
            end else begin
                div_start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        div_start = 1'b0;
        check("ignored start latency", 32'(k), 32'd35);
        check("ignored start result",  result, 32'd14);
        start_op(OP_DIVU, 32'd9, 32'd3);
        check("chained busy", {31'd0, div_busy}, 32'd1);
        check("chained done low", {31'd0, div_done}, 32'd0);
        finish_op("chained divu 9/3", 32'd3, 35);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
